tpu_seq_ctrl: RTL and testbench

//  Top-level operation sequencer between the APB config block and the TPU datapath.

---
 rtl/tpu_seq_ctrl_if.sv | 32 +++
 rtl/tpu_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tpu_seq_ctrl_if.sv
// Sequencer bus: config-block start/enables, matmul handshake, status back.
// The slave side is the sequencer; the master side is config block plus datapath.
interface tpu_seq_ctrl_if;
    logic       start_tpu;
    logic       enable_matmul;
    logic       enable_norm;
    logic       enable_pool;
    logic       enable_activation;
    logic       done_mat_mul;
    logic       start_mat_mul;
    logic       en_norm_o;
    logic       en_pool_o;
    logic       en_act_o;
    logic       busy;
    logic       done_tpu;
    logic       error_timeout;
    logic [2:0] state_o;

    modport master (
        output start_tpu, enable_matmul, enable_norm,
        output enable_pool, enable_activation, done_mat_mul,
        input  start_mat_mul, en_norm_o, en_pool_o, en_act_o,
        input  busy, done_tpu, error_timeout, state_o
    );

    modport slave (
        input  start_tpu, enable_matmul, enable_norm,
        input  enable_pool, enable_activation, done_mat_mul,
        output start_mat_mul, en_norm_o, en_pool_o, en_act_o,
        output busy, done_tpu, error_timeout, state_o
    );
endinterface

// File: rtl/tpu_seq_ctrl.sv
// TPU operation sequencer: start edge, matmul wait with timeout,
// post-stage drain timing, and done/busy/error status.
module tpu_seq_ctrl #(
    parameter int DRAIN_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic clk,
    input  logic reset,
    tpu_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MATMUL = 3'd1,
        DRAIN  = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DC = CNT_WIDTH'(DRAIN_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic [CNT_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [2:0]           en_q, en_d;
    logic                 start_prev;
    logic                 mm_q, busy_q, done_q, err_q;
    logic                 start_edge;
    logic [1:0]           n_en;
    logic [CNT_WIDTH-1:0] d_load;

    assign start_edge = bus.start_tpu & ~start_prev;
    assign n_en = {1'b0, bus.enable_norm} + {1'b0, bus.enable_pool}
                + {1'b0, bus.enable_activation};
    assign d_load = DC * CNT_WIDTH'(n_en);

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;
        en_d    = en_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    en_d   = {bus.enable_activation, bus.enable_pool,
                              bus.enable_norm};
                    dcnt_d = d_load;
                    tcnt_d = '0;
                    if (bus.enable_matmul)
                        state_d = MATMUL;
                    else if (d_load != '0)
                        state_d = DRAIN;
                    else
                        state_d = DONE;
                end
            end
            MATMUL: begin
                if (!bus.start_tpu) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    dcnt_d  = '0;
                    en_d    = '0;
                end else if (bus.done_mat_mul) begin
                    tcnt_d  = '0;
                    state_d = (dcnt_q != '0) ? DRAIN : DONE;
                end else if (tcnt_q == TO_LAST) begin
                    tcnt_d  = '0;
                    state_d = ERROR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.start_tpu) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    dcnt_d  = '0;
                    en_d    = '0;
                end else if (dcnt_q <= 1) begin
                    dcnt_d  = '0;
                    state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            DONE, ERROR: begin
                if (!bus.start_tpu) begin
                    state_d = IDLE;
                    en_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                tcnt_d  = '0;
                dcnt_d  = '0;
                en_d    = '0;
            end
        endcase
    end

    // Status flops decode the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
            en_q       <= '0;
            start_prev <= 1'b0;
            mm_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            dcnt_q     <= dcnt_d;
            en_q       <= en_d;
            start_prev <= bus.start_tpu;
            mm_q       <= (state_d == MATMUL);
            busy_q     <= (state_d == MATMUL) || (state_d == DRAIN);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERROR);
        end
    end

    assign bus.start_mat_mul = mm_q;
    assign bus.busy          = busy_q;
    assign bus.done_tpu      = done_q;
    assign bus.error_timeout = err_q;
    assign bus.en_norm_o     = en_q[0];
    assign bus.en_pool_o     = en_q[1];
    assign bus.en_act_o      = en_q[2];
    assign bus.state_o       = state_q;
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl: matmul/drain timing, timeout,
// abort, reset override and start edge behaviour.
module tb_tpu_seq_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    tpu_seq_ctrl_if bus ();

    tpu_seq_ctrl #(
        .DRAIN_CYCLES  (8),
        .TIMEOUT_CYCLES(32),
        .CNT_WIDTH     (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_en(input logic m, input logic n,
                          input logic p, input logic a);
        bus.enable_matmul     = m;
        bus.enable_norm       = n;
        bus.enable_pool       = p;
        bus.enable_activation = a;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".state"}, 32'(bus.state_o), 0);
        chk({tag, ".outs"},
            {25'd0, bus.start_mat_mul, bus.en_norm_o, bus.en_pool_o,
             bus.en_act_o, bus.busy, bus.done_tpu, bus.error_timeout}, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start_tpu    = 1'b0;
        bus.done_mat_mul = 1'b0;
        set_en(0, 0, 0, 0);
        step(2);
        chk_idle("reset");
        reset = 1'b0;
        step(1);

        // 1: matmul only, done 20 cycles after the edge
        set_en(1, 0, 0, 0);
        bus.start_tpu = 1'b1;
        step(1);
        chk("t1.state", 32'(bus.state_o), 1);
        chk("t1.busy", 32'(bus.busy), 1);
        for (int k = 1; k < 20; k++) begin
            chk("t1.mm_hi", 32'(bus.start_mat_mul), 1);
            step(1);
        end
        chk("t1.mm_n20", 32'(bus.start_mat_mul), 1);
        bus.done_mat_mul = 1'b1;
        step(1);
        bus.done_mat_mul = 1'b0;
        chk("t1.done", 32'(bus.done_tpu), 1);
        chk("t1.busy_lo", 32'(bus.busy), 0);
        chk("t1.mm_lo", 32'(bus.start_mat_mul), 0);
        chk("t1.st_done", 32'(bus.state_o), 3);
        step(3);
        chk("t1.hold", 32'(bus.state_o), 3);
        bus.start_tpu = 1'b0;
        step(1);
        chk_idle("t1.clr");

        // 2: matmul + norm + act, 16-cycle drain
        set_en(1, 1, 0, 1);
        bus.start_tpu = 1'b1;
        step(1);
        chk("t2.en", {29'd0, bus.en_act_o, bus.en_pool_o, bus.en_norm_o},
            32'b101);
        set_en(0, 0, 1, 0);
        step(4);
        bus.done_mat_mul = 1'b1;
        step(1);
        bus.done_mat_mul = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("t2.drain", 32'(bus.state_o), 2);
            chk("t2.busy", 32'(bus.busy), 1);
            step(1);
        end
        chk("t2.done", 32'(bus.done_tpu), 1);
        chk("t2.en_keep",
            {29'd0, bus.en_act_o, bus.en_pool_o, bus.en_norm_o}, 32'b101);
        bus.start_tpu = 1'b0;
        step(1);
        chk_idle("t2.clr");

        // 3: pool only, matmul off
        set_en(0, 0, 1, 0);
        bus.start_tpu = 1'b1;
        step(1);
        for (int k = 0; k < 8; k++) begin
            chk("t3.drain", 32'(bus.state_o), 2);
            chk("t3.mm_off", 32'(bus.start_mat_mul), 0);
            step(1);
        end
        chk("t3.done", 32'(bus.done_tpu), 1);
        chk("t3.mm_off2", 32'(bus.start_mat_mul), 0);
        bus.start_tpu = 1'b0;
        step(1);

        // 4: timeout after 32 matmul cycles
        set_en(1, 0, 0, 0);
        bus.start_tpu = 1'b1;
        step(1);
        step(31);
        chk("t4.last_mm", 32'(bus.state_o), 1);
        chk("t4.no_err", 32'(bus.error_timeout), 0);
        step(1);
        chk("t4.err", 32'(bus.error_timeout), 1);
        chk("t4.mm_lo", 32'(bus.start_mat_mul), 0);
        chk("t4.st", 32'(bus.state_o), 4);
        chk("t4.busy", 32'(bus.busy), 0);
        step(2);
        chk("t4.err_hold", 32'(bus.error_timeout), 1);
        bus.start_tpu = 1'b0;
        step(1);
        chk_idle("t4.clr");

        // done coinciding with the timeout cycle
        bus.start_tpu = 1'b1;
        step(32);
        bus.done_mat_mul = 1'b1;
        step(1);
        bus.done_mat_mul = 1'b0;
        chk("t4b.done_wins", 32'(bus.state_o), 3);
        chk("t4b.no_err", 32'(bus.error_timeout), 0);
        bus.start_tpu = 1'b0;
        step(1);

        // 5: abort in drain, then a stray done pulse in idle
        set_en(0, 0, 1, 0);
        bus.start_tpu = 1'b1;
        step(4);
        chk("t5.in_drain", 32'(bus.state_o), 2);
        bus.start_tpu = 1'b0;
        step(1);
        chk_idle("t5.abort");
        bus.done_mat_mul = 1'b1;
        step(1);
        bus.done_mat_mul = 1'b0;
        step(1);
        chk_idle("t5.stray");

        // 6: reset in matmul with start held high
        set_en(1, 0, 0, 0);
        bus.start_tpu = 1'b1;
        step(3);
        chk("t6.mm", 32'(bus.state_o), 1);
        reset = 1'b1;
        step(1);
        chk_idle("t6.rst");
        step(1);
        reset = 1'b0;
        step(1);
        chk("t6.restart", 32'(bus.state_o), 1);
        chk("t6.mm_hi", 32'(bus.start_mat_mul), 1);
        bus.done_mat_mul = 1'b1;
        step(1);
        bus.done_mat_mul = 1'b0;
        chk("t6.done", 32'(bus.done_tpu), 1);
        step(4);
        chk("t6.no_retrig", 32'(bus.state_o), 3);
        chk("t6.mm_lo", 32'(bus.start_mat_mul), 0);
        bus.start_tpu = 1'b0;
        step(1);
        chk_idle("t6.clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
